// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped, 4-word-block, write-through, no-allocate data cache.
// Define CACHE_PERF_CNT_EN to add saturating Hit_Count/Miss_Count outputs.
module cache_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OFFSET     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  Proc_Rd,
  input  logic                  Proc_Wr,
  input  logic [ADDR_WIDTH-1:0] Proc_Addr,
  input  logic [DATA_WIDTH-1:0] Proc_Data,
  output logic                  Stall,
  input  logic                  Miss,
  output logic                  Cache_Rd,
  output logic                  Cache_Wr,
  output logic                  Block_Wr,
  output logic                  Mem_Rd_Req,
  output logic                  Mem_Wr_Req,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] Mem_Wr_Data,
  input  logic                  Mem_Ready
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  Hit_Count,
  output logic [CNT_WIDTH-1:0]  Miss_Count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE_THRU,
    DONE
  } state_t;

  state_t state, state_n;
  logic   rd_start;
  logic   wr_start;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A simultaneous read and write is handled as a write.
  always_comb begin
    state_n  = state;
    Stall    = 1'b0;
    Cache_Rd = 1'b0;
    Cache_Wr = 1'b0;
    Block_Wr = 1'b0;
    rd_start = 1'b0;
    wr_start = 1'b0;
    unique case (state)
      IDLE: begin
        Cache_Rd = Proc_Rd && !Proc_Wr;
        Cache_Wr = Proc_Wr;
        if (Proc_Wr) begin
          Stall    = 1'b1;
          wr_start = 1'b1;
          state_n  = WRITE_THRU;
        end else if (Proc_Rd && Miss) begin
          Stall    = 1'b1;
          rd_start = 1'b1;
          state_n  = REFILL;
        end
      end
      REFILL: begin
        Stall = 1'b1;
        if (Mem_Ready) begin
          Block_Wr = 1'b1;
          state_n  = IDLE;
        end
      end
      WRITE_THRU: begin
        Stall = 1'b1;
        if (Mem_Ready) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      Mem_Rd_Req  <= 1'b0;
      Mem_Wr_Req  <= 1'b0;
      Mem_Addr    <= '0;
      Mem_Wr_Data <= '0;
    end else begin
      if (rd_start) begin
        Mem_Rd_Req <= 1'b1;
        Mem_Addr   <= {Proc_Addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
      end else if (state == REFILL && Mem_Ready) begin
        Mem_Rd_Req <= 1'b0;
      end
      if (wr_start) begin
        Mem_Wr_Req  <= 1'b1;
        Mem_Addr    <= Proc_Addr;
        Mem_Wr_Data <= Proc_Data;
      end else if (state == WRITE_THRU && Mem_Ready) begin
        Mem_Wr_Req <= 1'b0;
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // relook marks the IDLE cycle right after a refill, whose hit is not a new request.
  logic relook;
  logic req_seen;

  assign req_seen = (state == IDLE) && (Proc_Rd || Proc_Wr) && !relook;

  always_ff @(posedge CLK) begin
    if (rst) begin
      relook     <= 1'b0;
      Hit_Count  <= '0;
      Miss_Count <= '0;
    end else begin
      relook <= (state == REFILL) && Mem_Ready;
      if (req_seen && !Miss && !(&Hit_Count)) begin
        Hit_Count <= Hit_Count + CntOne;
      end
      if (req_seen && Miss && !(&Miss_Count)) begin
        Miss_Count <= Miss_Count + CntOne;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: IDLE decode table plus read/write/reset sequences
// against a small cache-array and main-memory model, with a data scoreboard.
module tb_cache_controller;

`ifdef CACHE_PERF_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic        CLK = 1'b0;
  logic        rst;
  logic        Proc_Rd, Proc_Wr;
  logic [9:0]  Proc_Addr;
  logic [31:0] Proc_Data;
  logic        Stall, Miss;
  logic        Cache_Rd, Cache_Wr, Block_Wr;
  logic        Mem_Rd_Req, Mem_Wr_Req;
  logic [9:0]  Mem_Addr;
  logic [31:0] Mem_Wr_Data;
  logic        Mem_Ready;
`ifdef CACHE_PERF_CNT_EN
  logic [CW-1:0] Hit_Count, Miss_Count;
`endif

  cache_controller #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .OFFSET(2),
    .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .Proc_Rd(Proc_Rd),
    .Proc_Wr(Proc_Wr),
    .Proc_Addr(Proc_Addr),
    .Proc_Data(Proc_Data),
    .Stall(Stall),
    .Miss(Miss),
    .Cache_Rd(Cache_Rd),
    .Cache_Wr(Cache_Wr),
    .Block_Wr(Block_Wr),
    .Mem_Rd_Req(Mem_Rd_Req),
    .Mem_Wr_Req(Mem_Wr_Req),
    .Mem_Addr(Mem_Addr),
    .Mem_Wr_Data(Mem_Wr_Data),
    .Mem_Ready(Mem_Ready)
`ifdef CACHE_PERF_CNT_EN
    ,
    .Hit_Count(Hit_Count),
    .Miss_Count(Miss_Count)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Environment: 16-line direct-mapped cache array and word-addressed main memory.
  logic [15:0] valid;
  logic [3:0]  tag [16];
  logic [31:0] cdata [64];
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        model_miss;
  logic        use_tbl;
  logic        tbl_miss;

  assign model_miss = !(valid[Proc_Addr[5:2]] && tag[Proc_Addr[5:2]] == Proc_Addr[9:6]);
  assign Miss = use_tbl ? tbl_miss : model_miss;

  always @(posedge CLK) begin
    if (Block_Wr) begin
      valid[Mem_Addr[5:2]] <= 1'b1;
      tag[Mem_Addr[5:2]]   <= Mem_Addr[9:6];
      for (int w = 0; w < 4; w++)
        cdata[Mem_Addr[5:2]*4 + w] <= mem[{Mem_Addr[9:2], 2'(w)}];
    end else if (Cache_Wr && !Miss) begin
      cdata[Proc_Addr[5:0]] <= Proc_Data;
    end
    if (Mem_Wr_Req && Mem_Ready)
      mem[Mem_Addr] <= Mem_Wr_Data;
  end

  // Memory responder: Mem_Ready comes mem_lat cycles after a request appears.
  int   mem_lat = 1;
  int   lat_cnt = 0;
  logic rdy = 1'b0;
  logic force_rdy = 1'b0;

  assign Mem_Ready = rdy | force_rdy;

  always @(negedge CLK) begin
    if ((Mem_Rd_Req || Mem_Wr_Req) && !rdy) begin
      lat_cnt++;
      if (lat_cnt >= mem_lat) rdy = 1'b1;
    end else begin
      rdy = 1'b0;
      lat_cnt = 0;
    end
  end

  logic [31:0] exp_q [$];

  task automatic do_read(input logic [9:0] a, input int lat, input int exp_st, input string nm);
    int  st = 0;
    int  bw = 0;
    bit  done = 0;
    logic [31:0] e;
    mem_lat = lat;
    @(negedge CLK);
    Proc_Rd = 1'b1;
    Proc_Addr = a;
    exp_q.push_back(ref_mem[a]);
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (Block_Wr) bw++;
      if (c == 1) begin
        check({nm, " rd_req"}, 32'(Mem_Rd_Req), 32'd1);
        check({nm, " rd_addr"}, 32'(Mem_Addr), 32'({a[9:2], 2'b00}));
      end
      if (!Stall) begin
        done = 1;
        e = exp_q.pop_front();
        check({nm, " data"}, cdata[a[5:0]], e);
      end else begin
        st++;
        @(negedge CLK);
      end
    end
    Proc_Rd = 1'b0;
    if (!done) check({nm, " timeout"}, 32'd0, 32'd1);
    check({nm, " stall_cycles"}, 32'(st), 32'(exp_st));
    check({nm, " block_wr_pulses"}, 32'(bw), (exp_st > 0) ? 32'd1 : 32'd0);
    if (exp_st == 0) check({nm, " no_mem_req"}, 32'(Mem_Rd_Req | Mem_Wr_Req), 32'd0);
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int lat, input string nm);
    int  st = 0;
    int  bw = 0;
    bit  done = 0;
    logic [31:0] e;
    mem_lat = lat;
    @(negedge CLK);
    Proc_Wr = 1'b1;
    Proc_Addr = a;
    Proc_Data = d;
    ref_mem[a] = d;
    exp_q.push_back(d);
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (Block_Wr) bw++;
      if (c == 1) begin
        check({nm, " wr_req"}, 32'(Mem_Wr_Req), 32'd1);
        check({nm, " wr_addr"}, 32'(Mem_Addr), 32'(a));
        check({nm, " wr_data"}, Mem_Wr_Data, d);
      end
      if (!Stall) begin
        done = 1;
        e = exp_q.pop_front();
        check({nm, " mem_word"}, mem[a], e);
        check({nm, " done_cache_wr"}, 32'(Cache_Wr), 32'd0);
      end else begin
        st++;
        @(negedge CLK);
      end
    end
    Proc_Wr = 1'b0;
    if (!done) check({nm, " timeout"}, 32'd0, 32'd1);
    check({nm, " stall_cycles"}, 32'(st), 32'(1 + lat));
    check({nm, " block_wr_pulses"}, 32'(bw), 32'd0);
  endtask

  typedef struct {
    logic rd, wr, miss;
    logic stall, crd, cwr;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] <= 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    valid <= '0;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    Proc_Rd = 1'b0;
    Proc_Wr = 1'b0;
    Proc_Addr = '0;
    Proc_Data = '0;
    use_tbl = 1'b0;
    tbl_miss = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("reset stall", 32'(Stall), 32'd0);
    check("reset rd_req", 32'(Mem_Rd_Req), 32'd0);
    check("reset wr_req", 32'(Mem_Wr_Req), 32'd0);
    check("reset mem_addr", 32'(Mem_Addr), 32'd0);
    check("reset wr_data", Mem_Wr_Data, 32'd0);
`ifdef CACHE_PERF_CNT_EN
    check("reset hit_count", 32'(Hit_Count), 32'd0);
    check("reset miss_count", 32'(Miss_Count), 32'd0);
`endif
    rst = 1'b0;

    // IDLE decode; inputs are withdrawn before the next edge.
    use_tbl = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      Proc_Rd = tbl[i].rd;
      Proc_Wr = tbl[i].wr;
      tbl_miss = tbl[i].miss;
      Proc_Addr = 10'h155;
      #1;
      check($sformatf("tbl%0d stall", i), 32'(Stall), 32'(tbl[i].stall));
      check($sformatf("tbl%0d cache_rd", i), 32'(Cache_Rd), 32'(tbl[i].crd));
      check($sformatf("tbl%0d cache_wr", i), 32'(Cache_Wr), 32'(tbl[i].cwr));
      check($sformatf("tbl%0d block_wr", i), 32'(Block_Wr), 32'd0);
      Proc_Rd = 1'b0;
      Proc_Wr = 1'b0;
    end
    use_tbl = 1'b0;

    do_read(10'h010, 3, 4, "cold_read_010");
    do_read(10'h013, 1, 0, "hit_read_013");
    do_write(10'h012, 32'hDEADBEEF, 2, "write_hit_012");
`ifdef CACHE_PERF_CNT_EN
    check("perf hits_after_3", 32'(Hit_Count), 32'd2);
    check("perf misses_after_3", 32'(Miss_Count), 32'd1);
`endif
    do_read(10'h012, 1, 0, "read_back_012");
    do_write(10'h3F0, 32'h1234_5678, 1, "write_miss_3f0");
    do_read(10'h3F0, 2, 3, "refill_3f0");
    do_read(10'h013, 1, 0, "hit_again_013");
`ifdef CACHE_PERF_CNT_EN
    check("perf hit_saturated", 32'(Hit_Count), 32'd3);
    check("perf miss_count", 32'(Miss_Count), 32'd3);
`endif

    // Reset during a refill: request dropped, no line fill, late ready ignored.
    mem_lat = 20;
    @(negedge CLK);
    Proc_Rd = 1'b1;
    Proc_Addr = 10'h020;
    #1;
    check("abort idle_stall", 32'(Stall), 32'd1);
    @(negedge CLK);
    #1;
    check("abort rd_req", 32'(Mem_Rd_Req), 32'd1);
    check("abort in_refill_stall", 32'(Stall), 32'd1);
    @(negedge CLK);
    rst = 1'b1;
    Proc_Rd = 1'b0;
    @(negedge CLK);
    #1;
    check("abort rd_req_cleared", 32'(Mem_Rd_Req), 32'd0);
    check("abort stall_cleared", 32'(Stall), 32'd0);
    check("abort block_wr", 32'(Block_Wr), 32'd0);
`ifdef CACHE_PERF_CNT_EN
    check("abort hit_count_reset", 32'(Hit_Count), 32'd0);
    check("abort miss_count_reset", 32'(Miss_Count), 32'd0);
`endif
    rst = 1'b0;
    @(negedge CLK);
    force_rdy = 1'b1;
    #1;
    check("late_ready block_wr", 32'(Block_Wr), 32'd0);
    @(negedge CLK);
    force_rdy = 1'b0;
    #1;
    check("late_ready rd_req", 32'(Mem_Rd_Req), 32'd0);
    check("late_ready stall", 32'(Stall), 32'd0);
    check("late_ready no_fill", 32'(valid[8]), 32'd0);
    do_read(10'h020, 2, 3, "refill_after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
